mant_align_2: RTL and testbench

//  Two-lane mantissa alignment stage of the Hadamard/butterfly datapath. Sits directly downstream of
//  the exponent-offset stage. Per lane: restores the hidden bit and right-shifts the significand by its

---
 rtl/mant_align_2.sv | 106 ++++++++++
 tb/tb_mant_align_2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mant_align_2.sv
// Two-lane mantissa alignment: hidden-bit restore, right shift by offset, sticky collect.
// Two-stage valid/ready pipeline feeding the add/sub stage.
module mant_align_2 #(
    parameter int expWidth  = 4,
    parameter int sigWidth  = 4,
    parameter int guardBits = 3,
    localparam int AW       = sigWidth + 1 + guardBits
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            input_sign,
    input  logic [2*expWidth-1:0] input_exp,
    input  logic [2*sigWidth-1:0] input_frac,
    input  logic [expWidth-1:0]   max_exp,
    input  logic [2*expWidth-1:0] exp_offset_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_sign,
    output logic [expWidth-1:0]   out_exp,
    output logic [2*AW-1:0]       aligned_mant,
    output logic [1:0]            sticky
);

    logic                          s1_valid, s2_valid;
    logic                          adv1, adv2;
    logic [1:0]                    s1_sign;
    logic [expWidth-1:0]           s1_exp;
    logic [1:0][AW-1:0]            s1_mant;
    logic [1:0][expWidth-1:0]      s1_off;
    logic [1:0][AW-1:0]            mant_in;
    logic [1:0][AW-1:0]            sh_mant;
    logic [1:0][AW-1:0]            sh_mask;
    logic [1:0]                    sh_sticky;
    logic [expWidth-1:0]           lane_exp;

    assign adv2      = ~s2_valid | out_ready;
    assign adv1      = ~s1_valid | adv2;
    assign in_ready  = adv1 & ~rst;
    assign out_valid = s2_valid;

    // Zero-exponent lanes carry no hidden bit and are treated as exact zeros.
    always_comb begin
        mant_in  = '0;
        lane_exp = '0;
        for (int i = 0; i < 2; i++) begin
            lane_exp = input_exp[expWidth*i +: expWidth];
            if (lane_exp != '0)
                mant_in[i] = {1'b1, input_frac[sigWidth*i +: sigWidth],
                              {guardBits{1'b0}}};
        end
    end

    always_comb begin
        sh_mant   = '0;
        sh_mask   = '0;
        sh_sticky = '0;
        for (int i = 0; i < 2; i++) begin
            if (int'(s1_off[i]) >= AW) begin
                sh_sticky[i] = |s1_mant[i];
            end else begin
                sh_mant[i]   = s1_mant[i] >> s1_off[i];
                sh_mask[i]   = ~({AW{1'b1}} << s1_off[i]);
                sh_sticky[i] = |(s1_mant[i] & sh_mask[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_off   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= input_sign;
                s1_exp  <= max_exp;
                s1_mant <= mant_in;
                s1_off  <= exp_offset_num;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_sign     <= '0;
            out_exp      <= '0;
            aligned_mant <= '0;
            sticky       <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign     <= s1_sign;
                out_exp      <= s1_exp;
                aligned_mant <= sh_mant;
                sticky       <= sh_sticky;
            end
        end
    end

endmodule

// File: tb/tb_mant_align_2.sv
// Scoreboard bench for mant_align_2: directed pairs, stalls, stream and reset flush.
// Expected responses are queued on acceptance and checked by an output monitor.
module tb_mant_align_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  input_sign;
    logic [7:0]  input_exp;
    logic [7:0]  input_frac;
    logic [3:0]  max_exp;
    logic [7:0]  exp_offset_num;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sign;
    logic [3:0]  out_exp;
    logic [15:0] aligned_mant;
    logic [1:0]  sticky;

    int vectors     = 0;
    int miscompares = 0;
    logic [23:0] q[$];
    logic [23:0] held;
    logic        prev_stall = 1'b0;
    logic        saw_full   = 1'b0;

    always #5 clk = ~clk;

    mant_align_2 dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .input_sign     (input_sign),
        .input_exp      (input_exp),
        .input_frac     (input_frac),
        .max_exp        (max_exp),
        .exp_offset_num (exp_offset_num),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sign       (out_sign),
        .out_exp        (out_exp),
        .aligned_mant   (aligned_mant),
        .sticky         (sticky)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Output monitor: pops on each completed handshake, checks stall stability.
    always @(negedge clk) begin
        logic [23:0] act;
        logic [23:0] exp;
        act = {out_sign, out_exp, aligned_mant, sticky};
        if (!rst) begin
            if (prev_stall) begin
                vectors++;
                if (act !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold act=%h exp=%h", act, held);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_out act=%h exp=none", act);
                end else begin
                    exp = q.pop_front();
                    if (act !== exp) begin
                        miscompares++;
                        $display("FAIL out_pair act=%h exp=%h", act, exp);
                    end
                end
            end
            if (out_valid && !out_ready && !in_ready)
                saw_full = 1'b1;
        end
        prev_stall = !rst && out_valid && !out_ready;
        held       = act;
    end

    task automatic send(input logic [1:0] sg, input logic [3:0] e1,
                        input logic [3:0] e0, input logic [3:0] f1,
                        input logic [3:0] f0, input logic [3:0] mx,
                        input logic [3:0] o1, input logic [3:0] o0,
                        input logic [7:0] m1, input logic [7:0] m0,
                        input logic [1:0] st);
        bit done;
        done           = 1'b0;
        in_valid       = 1'b1;
        input_sign     = sg;
        input_exp      = {e1, e0};
        input_frac     = {f1, f0};
        max_exp        = mx;
        exp_offset_num = {o1, o0};
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back({sg, mx, m1, m0, st});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout act=0 exp=1");
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 60 && q.size() != 0; c++)
            @(posedge clk);
        #1;
        chk(name, q.size(), 0);
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        input_sign     = '0;
        input_exp      = '0;
        input_frac     = '0;
        max_exp        = '0;
        exp_offset_num = '0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_outputs", {10'd0, out_sign, out_exp, aligned_mant}, 0);
        chk("rst_sticky", {30'd0, sticky}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);

        @(posedge clk);
        #1;
        send(2'b10, 4'd5, 4'd5, 4'h8, 4'h8, 4'd7, 4'd2, 4'd2,
             8'h30, 8'h30, 2'b00);
        in_valid = 1'b0;
        chk("lat_early", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_two", {31'd0, out_valid}, 1);
        drain("drain_t1");

        send(2'b01, 4'd3, 4'd3, 4'h8, 4'h8, 4'd9, 4'd7, 4'd6,
             8'h01, 8'h03, 2'b10);
        send(2'b11, 4'd0, 4'd3, 4'hF, 4'hF, 4'd3, 4'd9, 4'd4,
             8'h00, 8'h0F, 2'b01);
        send(2'b00, 4'd15, 4'd15, 4'h5, 4'h5, 4'd15, 4'd0, 4'd0,
             8'hA8, 8'hA8, 2'b00);
        send(2'b01, 4'd2, 4'd1, 4'h1, 4'h0, 4'd9, 4'd1, 4'd8,
             8'h44, 8'h00, 2'b01);
        send(2'b10, 4'd9, 4'd0, 4'h6, 4'h0, 4'd9, 4'd15, 4'd9,
             8'h00, 8'h00, 2'b10);
        in_valid = 1'b0;
        drain("drain_dir");

        fork
            begin
                send(2'd0, 4'd4, 4'd1, 4'hF, 4'h0, 4'd0, 4'd1, 4'd0,
                     8'h7C, 8'h80, 2'b00);
                send(2'd1, 4'd4, 4'd1, 4'hE, 4'h1, 4'd1, 4'd2, 4'd1,
                     8'h3C, 8'h44, 2'b00);
                send(2'd2, 4'd4, 4'd1, 4'hD, 4'h2, 4'd2, 4'd3, 4'd2,
                     8'h1D, 8'h24, 2'b00);
                send(2'd3, 4'd4, 4'd1, 4'hC, 4'h3, 4'd3, 4'd4, 4'd3,
                     8'h0E, 8'h13, 2'b00);
                send(2'd0, 4'd4, 4'd1, 4'hB, 4'h4, 4'd4, 4'd5, 4'd4,
                     8'h06, 8'h0A, 2'b10);
                send(2'd1, 4'd4, 4'd1, 4'hA, 4'h5, 4'd5, 4'd6, 4'd5,
                     8'h03, 8'h05, 2'b11);
                send(2'd2, 4'd4, 4'd1, 4'h9, 4'h6, 4'd6, 4'd7, 4'd6,
                     8'h01, 8'h02, 2'b11);
                send(2'd3, 4'd4, 4'd1, 4'h8, 4'h7, 4'd7, 4'd8, 4'd7,
                     8'h00, 8'h01, 2'b11);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 45; c++) begin
                    out_ready = (c % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_stream");
        chk("saw_both_full", {31'd0, saw_full}, 1);

        out_ready = 1'b0;
        send(2'b01, 4'd5, 4'd5, 4'h8, 4'h8, 4'd5, 4'd2, 4'd2,
             8'h30, 8'h30, 2'b00);
        send(2'b10, 4'd15, 4'd15, 4'h5, 4'h5, 4'd15, 4'd0, 4'd0,
             8'hA8, 8'hA8, 2'b00);
        in_valid = 1'b0;
        chk("inflight_valid", {31'd0, out_valid}, 1);
        #1;
        rst = 1'b1;
        #1;
        q.delete();
        chk("async_out_valid", {31'd0, out_valid}, 0);
        chk("async_outputs", {10'd0, out_sign, out_exp, aligned_mant}, 0);
        chk("async_sticky", {30'd0, sticky}, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_empty", {31'd0, out_valid}, 0);
        send(2'b11, 4'd3, 4'd3, 4'h8, 4'h8, 4'd9, 4'd7, 4'd6,
             8'h01, 8'h03, 2'b10);
        in_valid = 1'b0;
        chk("post_lat_early", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("post_lat_two", {31'd0, out_valid}, 1);
        drain("drain_final");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
